// File: rtl/mod_mul_pkg.sv
// Shared types, constants and helpers for the mod_mul_* engines.
// cond_sub works on a fixed MAXW-bit width. Callers widen their operands to MAXW
// bits and narrow the result, so NBITS+1 must not exceed MAXW.
package mod_mul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRECOMP = 2'd1,
        MUL     = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NBITS_DEF = 256;
    localparam int KBITS_DEF = 2;
    localparam int MAXW      = 1025;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int tbl_depth(input int k);
        return 1 << k;
    endfunction

    localparam int NDIG_DEF   = ceil_div(NBITS_DEF, KBITS_DEF);
    localparam int TDEPTH_DEF = tbl_depth(KBITS_DEF);

    // Single modular correction step. It is valid when x < 2*m.
    function automatic logic [MAXW-1:0] cond_sub(input logic [MAXW-1:0] x,
                                                 input logic [MAXW-1:0] m);
        return (x >= m) ? (x - m) : x;
    endfunction

endpackage

// File: rtl/mod_mul_il_radk_if.sv
// Start/result bus of the interleaved modular multiplier.
// enable_p is a one-cycle start request. It is taken only while the engine is idle
// (busy low). Requests seen while busy are dropped, not queued. done_irq_p and
// err_irq_p are single-cycle pulses. y holds its value until the next accepted start.
interface mod_mul_il_radk_if import mod_mul_pkg::*; #(
    parameter int NBITS = 256
);
    logic             enable_p;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] b;
    logic [NBITS-1:0] m;
    logic             busy;
    logic [NBITS-1:0] y;
    logic             done_irq_p;
    logic             err_irq_p;
    state_t           dbg_state;

    modport master (
        output enable_p, a, b, m,
        input  busy, y, done_irq_p, err_irq_p, dbg_state
    );

    modport slave (
        input  enable_p, a, b, m,
        output busy, y, done_irq_p, err_irq_p, dbg_state
    );
endinterface

// File: rtl/mod_dbl_red.sv
// One doubling stage: r = 2*t mod m, given t < m. The (NBITS+1)-bit double needs
// at most one subtraction of m.
module mod_dbl_red import mod_mul_pkg::*; #(
    parameter int NBITS = 256
) (
    input  logic [NBITS-1:0] t_i,
    input  logic [NBITS-1:0] m_i,
    output logic [NBITS-1:0] r_o
);
    logic [NBITS:0] dbl;

    // Double the input, then apply one conditional subtract.
    always_comb begin
        dbl = {t_i, 1'b0};
        r_o = NBITS'(cond_sub(MAXW'(dbl), MAXW'(m_i)));
    end
endmodule

// File: rtl/mod_mul_il_radk.sv
// Radix-2^KBITS interleaved modular multiplier, y = a*b mod m.
// The engine scans a MSB-first, one KBITS-bit digit per cycle.
// Build option: define MOD_MUL_OPERAND_CHECK_EN to reject a>=m, b>=m or m==0 at
// start with err_irq_p. Without the macro, err_irq_p is tied low.
// Latency from the accepting edge to done_irq_p: (2^KBITS-2) + NDIG + 1 cycles.
module mod_mul_il_radk import mod_mul_pkg::*; #(
    parameter int NBITS = NBITS_DEF,
    parameter int KBITS = KBITS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    mod_mul_il_radk_if.slave  bus
);
    localparam int NDIG   = ceil_div(NBITS, KBITS);
    localparam int AW     = NDIG * KBITS;
    localparam int TDEPTH = tbl_depth(KBITS);
    localparam int CW     = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    CNT_TOP = CW'(NDIG - 1);
    localparam logic [KBITS-1:0] J_LAST  = KBITS'(TDEPTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     a_q;
    logic [NBITS-1:0]  b_q, m_q, p_q, y_q;
    logic [NBITS-1:0]  d_q [TDEPTH];
    logic [CW-1:0]     cnt_q;
    logic [KBITS-1:0]  j_q;
    logic              busy_q, done_q;

    logic              op_bad, accept;
    logic [KBITS-1:0]  digit, j_prev;
    logic [NBITS-1:0]  p_shift, p_d, pre_d;
    logic [NBITS:0]    mul_sum, pre_sum;

`ifdef MOD_MUL_OPERAND_CHECK_EN
    logic err_q;
    assign op_bad        = (bus.a >= bus.m) || (bus.b >= bus.m) || (bus.m == '0);
    assign bus.err_irq_p = err_q;

    // A rejected start raises err for exactly one cycle and leaves everything else untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= bus.enable_p && (state_q == IDLE) && op_bad;
    end
`else
    assign op_bad        = 1'b0;
    assign bus.err_irq_p = 1'b0;
`endif

    assign accept = bus.enable_p && (state_q == IDLE) && !op_bad;

    // KBITS chained doubling stages: p_shift = 2^KBITS * P mod m.
    genvar g;
    generate
        for (g = 0; g < KBITS; g++) begin : g_dbl
            logic [NBITS-1:0] t_in, t_out;
            if (g == 0) begin : g_first
                assign t_in = p_q;
            end else begin : g_next
                assign t_in = g_dbl[g-1].t_out;
            end
            mod_dbl_red #(.NBITS(NBITS)) u_dbl (.t_i(t_in), .m_i(m_q), .r_o(t_out));
        end
    endgenerate
    assign p_shift = g_dbl[KBITS-1].t_out;

    // Datapath next values: the digit accumulate step and the table-build step.
    always_comb begin
        digit   = a_q[AW-1 -: KBITS];
        mul_sum = {1'b0, p_shift} + {1'b0, d_q[digit]};
        p_d     = NBITS'(cond_sub(MAXW'(mul_sum), MAXW'(m_q)));
        j_prev  = j_q - KBITS'(1);
        pre_sum = {1'b0, d_q[j_prev]} + {1'b0, b_q};
        pre_d   = NBITS'(cond_sub(MAXW'(pre_sum), MAXW'(m_q)));
    end

    // Next-state logic. The table build is skipped in radix 2 (nothing to precompute).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (KBITS > 1) ? PRECOMP : MUL;
            PRECOMP: if (j_q == J_LAST) state_d = MUL;
            MUL:     if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Operand latch, table build, digit loop and result publish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            p_q    <= '0;
            y_q    <= '0;
            cnt_q  <= '0;
            j_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < TDEPTH; i++) d_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q    <= AW'(bus.a);
                        b_q    <= bus.b;
                        m_q    <= bus.m;
                        d_q[0] <= '0;
                        d_q[1] <= bus.b;
                        p_q    <= '0;
                        cnt_q  <= CNT_TOP;
                        j_q    <= KBITS'(2);
                        busy_q <= 1'b1;
                    end
                end
                PRECOMP: begin
                    d_q[j_q] <= pre_d;
                    j_q      <= j_q + KBITS'(1);
                end
                MUL: begin
                    p_q   <= p_d;
                    a_q   <= a_q << KBITS;
                    cnt_q <= cnt_q - CW'(1);
                end
                DONE: begin
                    y_q    <= p_q;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.y          = y_q;
    assign bus.done_irq_p = done_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_mod_mul_il_radk.sv
// Bench for mod_mul_il_radk: four instances (KBITS 1..4, NBITS 8) sharing clk and rst_n.
`timescale 1ns/1ps
module tb_mod_mul_il_radk;
    import mod_mul_pkg::*;

    localparam int NB = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [NB-1:0] exp_q[$];

    logic          en_v [1:4];
    logic [NB-1:0] a_v  [1:4];
    logic [NB-1:0] b_v  [1:4];
    logic [NB-1:0] m_v  [1:4];

    mod_mul_il_radk_if #(.NBITS(NB)) if1(), if2(), if3(), if4();

    assign if1.enable_p = en_v[1]; assign if1.a = a_v[1]; assign if1.b = b_v[1]; assign if1.m = m_v[1];
    assign if2.enable_p = en_v[2]; assign if2.a = a_v[2]; assign if2.b = b_v[2]; assign if2.m = m_v[2];
    assign if3.enable_p = en_v[3]; assign if3.a = a_v[3]; assign if3.b = b_v[3]; assign if3.m = m_v[3];
    assign if4.enable_p = en_v[4]; assign if4.a = a_v[4]; assign if4.b = b_v[4]; assign if4.m = m_v[4];

    mod_mul_il_radk #(.NBITS(NB), .KBITS(1)) dut_k1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mod_mul_il_radk #(.NBITS(NB), .KBITS(2)) dut_k2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    mod_mul_il_radk #(.NBITS(NB), .KBITS(3)) dut_k3 (.clk(clk), .rst_n(rst_n), .bus(if3));
    mod_mul_il_radk #(.NBITS(NB), .KBITS(4)) dut_k4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    // ---------------- reference model ----------------
    function automatic logic [NB-1:0] ref_mulmod(input logic [NB-1:0] a, b, m);
        int p;
        p = int'(a) * int'(b);
        return NB'(p % int'(m));
    endfunction

    function automatic int lat_of(input int k);
        return ((1 << k) - 2) + (NB + k - 1) / k + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input int k, input logic en, input logic [NB-1:0] a, b, m);
        en_v[k] = en; a_v[k] = a; b_v[k] = b; m_v[k] = m;
    endtask

    // Call at a negedge. Returns at the negedge just after the accepting edge.
    task automatic start_op(input int k, input logic [NB-1:0] a, b, m);
        drive(k, 1'b1, a, b, m);
        @(negedge clk);
        en_v[k] = 1'b0;
    endtask

    task automatic peek(input int k, output logic bsy, output logic [NB-1:0] yv,
                        output logic dn, output logic er);
        case (k)
            1:       begin bsy = if1.busy; yv = if1.y; dn = if1.done_irq_p; er = if1.err_irq_p; end
            2:       begin bsy = if2.busy; yv = if2.y; dn = if2.done_irq_p; er = if2.err_irq_p; end
            3:       begin bsy = if3.busy; yv = if3.y; dn = if3.done_irq_p; er = if3.err_irq_p; end
            default: begin bsy = if4.busy; yv = if4.y; dn = if4.done_irq_p; er = if4.err_irq_p; end
        endcase
    endtask

    // Waits up to budget cycles for done. lat is -1 if done never arrives.
    task automatic wait_done(input int k, input int budget, output int lat,
                             output logic [NB-1:0] yv, output logic busy_ok,
                             output logic err_seen);
        logic bsy, dn, er;
        logic [NB-1:0] yy;
        lat = -1; yv = '0; busy_ok = 1'b1; err_seen = 1'b0;
        peek(k, bsy, yy, dn, er);
        if (bsy !== 1'b1) busy_ok = 1'b0;
        if (er === 1'b1) err_seen = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            peek(k, bsy, yy, dn, er);
            if (er === 1'b1) err_seen = 1'b1;
            if (dn === 1'b1) begin
                lat = c; yv = yy;
                if (bsy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (bsy !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic bsy, dn, er;
        logic [NB-1:0] yy;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            peek(k, bsy, yy, dn, er);
            n_checks++; if (yy !== '0)   begin n_fail++; $display("FAIL reset_y k=%0d: got %0d expected 0", k, yy); end
            n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL reset_busy k=%0d: got %b expected 0", k, bsy); end
            n_checks++; if (dn !== 1'b0)  begin n_fail++; $display("FAIL reset_done k=%0d: got %b expected 0", k, dn); end
            n_checks++; if (er !== 1'b0)  begin n_fail++; $display("FAIL reset_err k=%0d: got %b expected 0", k, er); end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat; logic [NB-1:0] yv, ex, yy; logic bok, es, bsy, dn, er;
        exp_q.push_back(8'd131);
        @(negedge clk);
        start_op(2, 8'd200, 8'd150, 8'd251);
        wait_done(2, 40, lat, yv, bok, es);
        ex = exp_q.pop_front();
        n_checks++; if (yv !== ex)   begin n_fail++; $display("FAIL basic_y: got %0d expected %0d", yv, ex); end
        n_checks++; if (lat != 7)    begin n_fail++; $display("FAIL basic_lat: got %0d expected 7", lat); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", bok); end
        n_checks++; if (es !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", es); end
        repeat (3) @(negedge clk);
        peek(2, bsy, yy, dn, er);
        n_checks++; if (yy !== 8'd131) begin n_fail++; $display("FAIL basic_hold_y: got %0d expected 131", yy); end
        n_checks++; if (dn !== 1'b0)   begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", dn); end
    endtask

    task automatic test_radix2;
        int lat; logic [NB-1:0] yv, ex; logic bok, es;
        exp_q.push_back(8'd3);
        @(negedge clk);
        start_op(1, 8'd13, 8'd7, 8'd11);
        wait_done(1, 40, lat, yv, bok, es);
        ex = exp_q.pop_front();
        n_checks++; if (yv !== ex)    begin n_fail++; $display("FAIL radix2_y: got %0d expected %0d", yv, ex); end
        n_checks++; if (lat != 9)     begin n_fail++; $display("FAIL radix2_lat: got %0d expected 9", lat); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL radix2_busy: got %b expected 1", bok); end
    endtask

    task automatic test_edge;
        logic [NB-1:0] ta [3] = '{8'd0, 8'd1, 8'd0};
        logic [NB-1:0] tb [3] = '{8'd77, 8'd250, 8'd0};
        logic [NB-1:0] tm [3] = '{8'd100, 8'd251, 8'd1};
        logic [NB-1:0] ty [3] = '{8'd0, 8'd250, 8'd0};
        int lat; logic [NB-1:0] yv, ex; logic bok, es;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ty[i]);
            @(negedge clk);
            start_op(2, ta[i], tb[i], tm[i]);
            wait_done(2, 40, lat, yv, bok, es);
            ex = exp_q.pop_front();
            n_checks++; if (yv !== ex) begin n_fail++; $display("FAIL edge_y case %0d: got %0d expected %0d", i, yv, ex); end
            n_checks++; if (lat != 7)  begin n_fail++; $display("FAIL edge_lat case %0d: got %0d expected 7", i, lat); end
        end
    endtask

    task automatic test_restart_ignored;
        int lat = -1, ndone = 0; logic [NB-1:0] ydone = '0, ex, yy; logic bsy, dn, er;
        exp_q.push_back(8'd131);
        @(negedge clk);
        start_op(2, 8'd200, 8'd150, 8'd251);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            peek(2, bsy, yy, dn, er);
            if (dn === 1'b1) begin
                ndone++;
                if (lat < 0) begin lat = c; ydone = yy; end
            end
            if (c == 3) drive(2, 1'b1, 8'd5, 8'd6, 8'd7);
            if (c == 4) en_v[2] = 1'b0;
        end
        ex = exp_q.pop_front();
        n_checks++; if (ydone !== ex) begin n_fail++; $display("FAIL restart_y: got %0d expected %0d", ydone, ex); end
        n_checks++; if (lat != 7)     begin n_fail++; $display("FAIL restart_lat: got %0d expected 7", lat); end
        n_checks++; if (ndone != 1)   begin n_fail++; $display("FAIL restart_ndone: got %0d expected 1", ndone); end
        n_checks++; if (yy !== ex)    begin n_fail++; $display("FAIL restart_hold_y: got %0d expected %0d", yy, ex); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [NB-1:0] yv, ex; logic bok, es;
        exp_q.push_back(ref_mulmod(8'd77, 8'd88, 8'd97));
        exp_q.push_back(ref_mulmod(8'd3, 8'd250, 8'd251));
        @(negedge clk);
        start_op(2, 8'd77, 8'd88, 8'd97);
        wait_done(2, 40, lat, yv, bok, es);
        ex = exp_q.pop_front();
        n_checks++; if (yv !== ex) begin n_fail++; $display("FAIL b2b_y0: got %0d expected %0d", yv, ex); end
        start_op(2, 8'd3, 8'd250, 8'd251);
        wait_done(2, 40, lat, yv, bok, es);
        ex = exp_q.pop_front();
        n_checks++; if (yv !== ex)    begin n_fail++; $display("FAIL b2b_y1: got %0d expected %0d", yv, ex); end
        n_checks++; if (lat != 7)     begin n_fail++; $display("FAIL b2b_lat1: got %0d expected 7", lat); end
        n_checks++; if (bok !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1: got %b expected 1", bok); end
    endtask

    task automatic test_reset_mid;
        int lat, ndone = 0; logic [NB-1:0] yv, ex, yy; logic bok, es, bsy, dn, er;
        @(negedge clk);
        start_op(2, 8'd200, 8'd150, 8'd251);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        peek(2, bsy, yy, dn, er);
        n_checks++; if (yy !== '0)    begin n_fail++; $display("FAIL rstmid_y: got %0d expected 0", yy); end
        n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bsy); end
        n_checks++; if (dn !== 1'b0)  begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", dn); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            peek(2, bsy, yy, dn, er);
            if (dn === 1'b1) ndone++;
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", ndone); end
        exp_q.push_back(ref_mulmod(8'd200, 8'd150, 8'd251));
        start_op(2, 8'd200, 8'd150, 8'd251);
        wait_done(2, 40, lat, yv, bok, es);
        ex = exp_q.pop_front();
        n_checks++; if (yv !== ex) begin n_fail++; $display("FAIL rstmid_fresh_y: got %0d expected %0d", yv, ex); end
        n_checks++; if (lat != 7)  begin n_fail++; $display("FAIL rstmid_fresh_lat: got %0d expected 7", lat); end
    endtask

    task automatic test_random;
        int lat; logic [NB-1:0] yv, ex, a, b, m; logic bok, es;
        for (int k = 1; k <= 4; k++) begin
            for (int i = 0; i < 12; i++) begin
                m = NB'($urandom_range(1, 255));
                a = NB'($urandom_range(0, int'(m) - 1));
                b = NB'($urandom_range(0, int'(m) - 1));
                exp_q.push_back(ref_mulmod(a, b, m));
                @(negedge clk);
                start_op(k, a, b, m);
                wait_done(k, 60, lat, yv, bok, es);
                ex = exp_q.pop_front();
                n_checks++;
                if (yv !== ex) begin
                    n_fail++;
                    $display("FAIL rand_y k=%0d a=%0d b=%0d m=%0d: got %0d expected %0d", k, a, b, m, yv, ex);
                end
                n_checks++;
                if (lat != lat_of(k)) begin
                    n_fail++;
                    $display("FAIL rand_lat k=%0d: got %0d expected %0d", k, lat, lat_of(k));
                end
                n_checks++;
                if (es !== 1'b0) begin n_fail++; $display("FAIL rand_err k=%0d: got %b expected 0", k, es); end
            end
        end
    endtask

`ifdef MOD_MUL_OPERAND_CHECK_EN
    task automatic test_operand_check;
        logic [NB-1:0] ba [3] = '{8'd251, 8'd5, 8'd0};
        logic [NB-1:0] bb [3] = '{8'd3, 8'd9, 8'd0};
        logic [NB-1:0] bm [3] = '{8'd251, 8'd9, 8'd0};
        int lat, ndone; logic [NB-1:0] yv, ex, yy; logic bok, es, bsy, dn, er;
        exp_q.push_back(ref_mulmod(8'd10, 8'd20, 8'd251));
        @(negedge clk);
        start_op(2, 8'd10, 8'd20, 8'd251);
        wait_done(2, 40, lat, yv, bok, es);
        ex = exp_q.pop_front();
        n_checks++; if (yv !== ex) begin n_fail++; $display("FAIL opchk_prev_y: got %0d expected %0d", yv, ex); end
        for (int i = 0; i < 3; i++) begin
            ndone = 0;
            @(negedge clk);
            start_op(2, ba[i], bb[i], bm[i]);
            peek(2, bsy, yy, dn, er);
            n_checks++; if (er !== 1'b1)  begin n_fail++; $display("FAIL opchk_err case %0d: got %b expected 1", i, er); end
            n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL opchk_busy case %0d: got %b expected 0", i, bsy); end
            n_checks++; if (yy !== ex)    begin n_fail++; $display("FAIL opchk_y case %0d: got %0d expected %0d", i, yy, ex); end
            @(negedge clk);
            peek(2, bsy, yy, dn, er);
            n_checks++; if (er !== 1'b0)  begin n_fail++; $display("FAIL opchk_err_pulse case %0d: got %b expected 0", i, er); end
            for (int c = 0; c < 10; c++) begin
                if (dn === 1'b1) ndone++;
                @(negedge clk);
                peek(2, bsy, yy, dn, er);
            end
            n_checks++; if (ndone != 0) begin n_fail++; $display("FAIL opchk_no_done case %0d: got %0d expected 0", i, ndone); end
        end
    endtask
`endif

    // ---------------- main sequence and report ----------------
    initial begin
        for (int k = 1; k <= 4; k++) drive(k, 1'b0, '0, '0, 8'd1);
        test_reset;
        test_basic;
        test_radix2;
        test_edge;
        test_restart_ignored;
        test_back_to_back;
        test_reset_mid;
        test_random;
`ifdef MOD_MUL_OPERAND_CHECK_EN
        test_operand_check;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
